sched_age_buffer: RTL and testbench

- Request holding buffer on the scheduler side that produces the per-entry age counters consumed by the scheduler's argmax stage.
- Accepts the winning index back from that stage and issues and retires the selected entry.
- Sits between the command front-end (enqueue side) and the DDR4 command sequencer (issue side).
- Forms the other end of the counter/index interface to the max-selection logic.

---
 rtl/sched_pkg.sv | 32 +++
 rtl/sched_age_buffer_if.sv | 25 ++
 rtl/sched_free_slot_enc.sv | 22 ++
 rtl/sched_age_buffer.sv | 125 ++++++++++++
 tb/tb_sched_age_buffer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sched_pkg.sv
// Shared types and constants for the scheduler age buffer and its argmax partner.
package sched_pkg;

    localparam int BUFF_LEN = 8;
    localparam int REQ_W    = 32;
    localparam int AGE_W    = 16;
    localparam int IDX_W    = 3;
    localparam int OCC_W    = 4;

    localparam logic [AGE_W-1:0] STARVE_THRESH = 16'd1024;

    typedef logic [AGE_W-1:0]               age_t;
    typedef logic [IDX_W-1:0]               idx_t;
    typedef logic [REQ_W-1:0]               req_t;
    typedef logic [OCC_W-1:0]               occ_t;
    typedef logic [BUFF_LEN-1:0]            valid_vec_t;
    typedef logic [BUFF_LEN-1:0][AGE_W-1:0] age_vec_t;

    // What a slot does at the coming clock edge.
    typedef enum logic [1:0] {
        SLOT_HOLD,
        SLOT_AGE,
        SLOT_FILL,
        SLOT_CLEAR
    } slot_op_t;

    // Ages saturate so an ancient entry keeps winning argmax instead of wrapping to young.
    function automatic age_t age_sat_inc(input age_t a);
        return (a == '1) ? a : age_t'(a + age_t'(1));
    endfunction

endpackage

// File: rtl/sched_age_buffer_if.sv
// Enqueue, issue and counter bundle between front-end/sequencer and the age buffer.
interface sched_age_buffer_if;
    import sched_pkg::*;

    logic     in_valid;
    req_t     in_req;
    logic     in_ready;
    age_vec_t counters;
    idx_t     sel_idx;
    logic     issue_valid;
    req_t     issue_req;
    logic     issue_ready;
    occ_t     occupancy;

    modport master (
        output in_valid, in_req, sel_idx, issue_ready,
        input  in_ready, counters, issue_valid, issue_req, occupancy
    );

    modport slave (
        input  in_valid, in_req, sel_idx, issue_ready,
        output in_ready, counters, issue_valid, issue_req, occupancy
    );

endinterface

// File: rtl/sched_free_slot_enc.sv
// Priority encoder: lowest-index free slot of the valid vector plus an any-free flag.
module sched_free_slot_enc
    import sched_pkg::*;
(
    input  valid_vec_t valid,
    output idx_t       free_idx,
    output logic       any_free
);

    // Scan from the top down so the last hit, the lowest free index, wins.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = BUFF_LEN - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = idx_t'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sched_age_buffer.sv
// Request holding buffer producing per-slot age counters for argmax and issuing the selected slot.
// Optional starvation alarm output is built when SCHED_STARVE_ALARM_EN is defined.
module sched_age_buffer
    import sched_pkg::*;
(
    input  logic clock,
    input  logic reset,
    sched_age_buffer_if.slave bus
`ifdef SCHED_STARVE_ALARM_EN
    ,
    output logic starve
`endif
);

    valid_vec_t valid;
    age_vec_t   age;
    req_t       payload [BUFF_LEN];
    occ_t       occupancy_q;
    idx_t       free_idx;
    logic       any_free;
    logic       in_ready;
    logic       enq_fire;
    logic       issue_fire;
    slot_op_t   slot_op [BUFF_LEN];

    sched_free_slot_enc u_free_enc (
        .valid    (valid),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    // Freed slots only become visible through the registered count, so there is no same-cycle reuse.
    assign in_ready   = (occupancy_q != occ_t'(BUFF_LEN));
    assign enq_fire   = bus.in_valid && in_ready && any_free;
    assign issue_fire = valid[bus.sel_idx] && bus.issue_ready;

    assign bus.in_ready    = in_ready;
    assign bus.counters    = age;
    assign bus.issue_valid = valid[bus.sel_idx];
    assign bus.issue_req   = payload[bus.sel_idx];
    assign bus.occupancy   = occupancy_q;

    // The enqueue target comes from the pre-issue valid vector, so it never collides with sel_idx.
    always_comb begin
        for (int i = 0; i < BUFF_LEN; i++) begin
            slot_op[i] = SLOT_HOLD;
            if (issue_fire && (bus.sel_idx == idx_t'(i))) begin
                slot_op[i] = SLOT_CLEAR;
            end else if (enq_fire && (free_idx == idx_t'(i))) begin
                slot_op[i] = SLOT_FILL;
            end else if (valid[i]) begin
                slot_op[i] = SLOT_AGE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
            age   <= '0;
        end else begin
            for (int i = 0; i < BUFF_LEN; i++) begin
                case (slot_op[i])
                    SLOT_CLEAR: begin
                        valid[i] <= 1'b0;
                        age[i]   <= '0;
                    end
                    SLOT_FILL: begin
                        valid[i] <= 1'b1;
                        age[i]   <= age_t'(1);
                    end
                    SLOT_AGE: begin
                        age[i] <= age_sat_inc(age[i]);
                    end
                    default: begin
                        age[i] <= age[i];
                    end
                endcase
            end
        end
    end

    // Payloads are don't-care while a slot is empty, so they carry no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < BUFF_LEN; i++) begin
            if (slot_op[i] == SLOT_FILL) begin
                payload[i] <= bus.in_req;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occupancy_q <= '0;
        end else begin
            case ({enq_fire, issue_fire})
                2'b10:   occupancy_q <= occupancy_q + occ_t'(1);
                2'b01:   occupancy_q <= occupancy_q - occ_t'(1);
                default: occupancy_q <= occupancy_q;
            endcase
        end
    end

`ifdef SCHED_STARVE_ALARM_EN
    logic starve_any;

    always_comb begin
        starve_any = 1'b0;
        for (int i = 0; i < BUFF_LEN; i++) begin
            if (valid[i] && (age[i] >= STARVE_THRESH)) begin
                starve_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve <= 1'b0;
        end else begin
            starve <= starve_any;
        end
    end
`endif

endmodule

// File: tb/tb_sched_age_buffer.sv
// Scoreboard bench for sched_age_buffer: arrival-time reference model, directed scenarios plus random traffic.
module tb_sched_age_buffer;
    import sched_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    sched_age_buffer_if bus ();

`ifdef SCHED_STARVE_ALARM_EN
    logic starve;
`endif

    sched_age_buffer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
`ifdef SCHED_STARVE_ALARM_EN
        ,
        .starve(starve)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: a slot remembers when it arrived; its age is elapsed cycles, clipped.
    localparam longint AGE_MAX = (64'd1 << AGE_W) - 1;

    bit     m_valid [BUFF_LEN];
    req_t   m_req   [BUFF_LEN];
    longint m_enq   [BUFF_LEN];
    longint now = 0;
    req_t   exp_q [$];
    int     checks = 0;
    int     errors = 0;
    int     tgt;
    bit     enq_f;
    bit     iss_f;
`ifdef SCHED_STARVE_ALARM_EN
    bit     m_starve = 1'b0;
    bit     st;
`endif

    function automatic longint m_age(input int i);
        longint d;
        if (!m_valid[i]) return 0;
        d = now - m_enq[i];
        return (d > AGE_MAX) ? AGE_MAX : d;
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < BUFF_LEN; i++) n += m_valid[i] ? 1 : 0;
        return n;
    endfunction

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUFF_LEN; i++) m_valid[i] = 1'b0;
            exp_q.delete();
`ifdef SCHED_STARVE_ALARM_EN
            m_starve = 1'b0;
`endif
        end else begin
`ifdef SCHED_STARVE_ALARM_EN
            st = 1'b0;
            for (int i = 0; i < BUFF_LEN; i++)
                if (m_valid[i] && m_age(i) >= longint'(STARVE_THRESH)) st = 1'b1;
            m_starve = st;
`endif
            enq_f = bus.in_valid && (m_occ() != BUFF_LEN);
            tgt = -1;
            for (int i = BUFF_LEN - 1; i >= 0; i--) if (!m_valid[i]) tgt = i;
            iss_f = bus.issue_ready && m_valid[bus.sel_idx];
            now++;
            if (iss_f) m_valid[bus.sel_idx] = 1'b0;
            if (enq_f) begin
                m_valid[tgt] = 1'b1;
                m_req[tgt]   = bus.in_req;
                m_enq[tgt]   = now - 1;
            end
        end
    end

    // Drive one cycle of inputs and predict whether an issue will fire at the next edge.
    task automatic apply_stimulus(input bit v, input req_t r, input idx_t s, input bit rdy);
        @(posedge clock);
        #1;
        bus.in_valid    = v;
        bus.in_req      = r;
        bus.sel_idx     = s;
        bus.issue_ready = rdy;
        if (rdy && m_valid[s]) exp_q.push_back(m_req[s]);
    endtask

    // Monitor: per-cycle state comparison plus scoreboard pop on every DUT issue.
    always @(negedge clock) begin
        age_vec_t exp_cnt;
        req_t     exp_req;
        for (int i = 0; i < BUFF_LEN; i++) exp_cnt[i] = age_t'(m_age(i));
        checks++;
        if (bus.counters !== exp_cnt) begin
            errors++;
            $display("[TB] FAIL counters: got %h, expected %h (t=%0t)", bus.counters, exp_cnt, $time);
        end
        check_output("occupancy", longint'(bus.occupancy), longint'(m_occ()));
        check_output("in_ready", longint'(bus.in_ready), (m_occ() != BUFF_LEN) ? 1 : 0);
        check_output("issue_valid", longint'(bus.issue_valid), longint'(m_valid[bus.sel_idx]));
`ifdef SCHED_STARVE_ALARM_EN
        check_output("starve", longint'(starve), longint'(m_starve));
`endif
        if (bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL issue_unexpected: got issue of %h, expected none (t=%0t)", bus.issue_req, $time);
            end else begin
                exp_req = exp_q.pop_front();
                check_output("issue_req", longint'(bus.issue_req), longint'(exp_req));
            end
        end else if (exp_q.size() != 0) begin
            checks++;
            errors++;
            exp_req = exp_q.pop_front();
            $display("[TB] FAIL issue_missing: got no issue, expected %h (t=%0t)", exp_req, $time);
        end
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_req      = '0;
        bus.sel_idx     = '0;
        bus.issue_ready = 1'b0;

        #1 reset = 1'b1;
        #2;
        check_output("rst_counters", (bus.counters == '0) ? 1 : 0, 1);
        check_output("rst_occupancy", longint'(bus.occupancy), 0);
        check_output("rst_in_ready", longint'(bus.in_ready), 1);
        check_output("rst_issue_valid", longint'(bus.issue_valid), 0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;

        // Three back-to-back enqueues land in slots 0..2 with staggered ages.
        apply_stimulus(1'b1, 32'hA000_000A, 3'd0, 1'b0);
        apply_stimulus(1'b1, 32'hB000_000B, 3'd0, 1'b0);
        apply_stimulus(1'b1, 32'hC000_000C, 3'd0, 1'b0);
        apply_stimulus(1'b0, '0, 3'd0, 1'b0);
        @(negedge clock);
        check_output("abc_age0", longint'(bus.counters[0]), 3);
        check_output("abc_age1", longint'(bus.counters[1]), 2);
        check_output("abc_age2", longint'(bus.counters[2]), 1);
        check_output("abc_occ", longint'(bus.occupancy), 3);

        // Fill to 8, then hold a ninth request against a full buffer.
        for (int k = 3; k < 8; k++) apply_stimulus(1'b1, req_t'(32'hD000_0000 + k), 3'd0, 1'b0);
        apply_stimulus(1'b1, 32'h9999_0009, 3'd0, 1'b0);
        @(negedge clock);
        check_output("full_in_ready", longint'(bus.in_ready), 0);
        check_output("full_occ", longint'(bus.occupancy), 8);
        apply_stimulus(1'b1, 32'h9999_0009, 3'd0, 1'b0);
        apply_stimulus(1'b1, 32'h9999_0009, 3'd0, 1'b0);
        @(negedge clock);
        check_output("full_hold_occ", longint'(bus.occupancy), 8);

        // Full buffer: issue slot 5 while the held request waits; it lands in slot 5 next cycle.
        apply_stimulus(1'b1, 32'h9999_0009, 3'd5, 1'b1);
        apply_stimulus(1'b1, 32'h9999_0009, 3'd5, 1'b0);
        @(negedge clock);
        check_output("reuse_in_ready", longint'(bus.in_ready), 1);
        check_output("reuse_occ", longint'(bus.occupancy), 7);
        apply_stimulus(1'b0, '0, 3'd5, 1'b0);
        @(negedge clock);
        check_output("reuse_age5", longint'(bus.counters[5]), 1);
        check_output("reuse_req5", longint'(bus.issue_req), 32'h9999_0009);

        // Drain to half full, refill slot 0, then issue slot 0 while enqueueing.
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        apply_stimulus(1'b0, '0, 3'd2, 1'b1);
        apply_stimulus(1'b0, '0, 3'd4, 1'b1);
        apply_stimulus(1'b0, '0, 3'd6, 1'b1);
        apply_stimulus(1'b1, 32'hE000_000E, 3'd0, 1'b0);
        apply_stimulus(1'b1, 32'hF000_000F, 3'd0, 1'b1);
        apply_stimulus(1'b0, '0, 3'd2, 1'b0);
        @(negedge clock);
        check_output("simul_occ", longint'(bus.occupancy), 5);
        check_output("simul_age0", longint'(bus.counters[0]), 0);
        check_output("simul_age2", longint'(bus.counters[2]), 1);
        check_output("simul_req2", longint'(bus.issue_req), 32'hF000_000F);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++)
            apply_stimulus(1'($urandom_range(0, 1)), req_t'($urandom), idx_t'($urandom_range(0, 7)),
                           1'($urandom_range(0, 1)));

        // Asynchronous reset in the middle of traffic.
        apply_stimulus(1'b1, 32'h1234_5678, 3'd1, 1'b1);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check_output("async_counters", (bus.counters == '0) ? 1 : 0, 1);
        check_output("async_occ", longint'(bus.occupancy), 0);
        check_output("async_issue_valid", longint'(bus.issue_valid), 0);
        check_output("async_in_ready", longint'(bus.in_ready), 1);
        bus.in_valid    = 1'b0;
        bus.issue_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_output("async_hold_in_ready", longint'(bus.in_ready), 1);
        #2 reset = 1'b0;

        // One long-lived entry saturates; issue_ready at an empty slot must do nothing.
        apply_stimulus(1'b1, 32'h5A5A_5A5A, 3'd0, 1'b0);
        for (int k = 0; k < 70000; k++) apply_stimulus(1'b0, '0, 3'd3, 1'b1);
        @(negedge clock);
        check_output("sat_age", longint'(bus.counters[0]), 16'hFFFF);
        check_output("sat_occ", longint'(bus.occupancy), 1);
`ifdef SCHED_STARVE_ALARM_EN
        check_output("sat_starve", longint'(starve), 1);
`endif
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        apply_stimulus(1'b0, '0, 3'd0, 1'b0);
        apply_stimulus(1'b0, '0, 3'd0, 1'b0);
        @(negedge clock);
        check_output("drain_occ", longint'(bus.occupancy), 0);
`ifdef SCHED_STARVE_ALARM_EN
        check_output("drain_starve", longint'(starve), 0);
`endif

        repeat (2) @(negedge clock);
        check_output("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
